xor_stream_cipher: RTL
======================

Name: xor_stream_cipher

Overview:
- Parametrised successor to the single-byte XOR cipher tile.
- Encrypts or decrypts a word stream of configurable width with valid/ready handshakes on both sides.
- Two keystream modes: repeating static key, or a Galois LFSR seeded from the key.
- Sits between the tile pin mux and the user datapath; it is symmetric, so the same instance decrypts.

Parameters:
- DATA_W, 8, data word width in bits; must be at least 1.
- KEY_W, 32, key and LFSR width; KEY_W must be ≥ DATA_W and KEY_W % DATA_W == 0.
- TAPS, 32'h80200003, Galois LFSR feedback mask; KEY_W bits wide.
- CNT_W, 16, width of the processed-word counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-high reset.
- key_ld  in  1  request to load key_in and mode; single-cycle pulse.
- key_in  in  KEY_W  key or LFSR seed.
- mode  in  1  0 = static repeating key, 1 = LFSR keystream.
- in_valid  in  1  input word valid.
- in_ready  out  1  block accepts the input word.
- in_data  in  DATA_W  plaintext or ciphertext word.
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer accepts the output word.
- out_data  out  DATA_W  in_data XOR keystream.
- keyed  out  1  a key is loaded and the block is in RUN.
- word_cnt  out  CNT_W  words accepted since the last key load; wraps.

Behaviour:
- Reset (asynchronous, active-high):
  - state = NOKEY; key_reg and lfsr = 0; mode_reg = 0; key index = 0.
  - out_valid = 0, out_data = 0, in_ready = 0, keyed = 0, word_cnt = 0.
- NOKEY state:
  - in_ready = 0.
  - key_ld = 1 loads key_reg, mode_reg and lfsr; key index = 0; word_cnt = 0; next state is RUN.
- RUN state:
  - in_ready = !out_valid || out_ready (one-stage output register with pass-through on drain).
  - A word is accepted on a cycle where in_valid && in_ready.
  - On accept: out_data <= in_data ^ ks; out_valid <= 1; word_cnt++ (wraps modulo 2^CNT_W).
  - Latency is 1 cycle. Throughput is 1 word per cycle while out_ready = 1.
  - out_valid clears on out_ready && !accept. With out_valid = 1 and out_ready = 0, out_data holds stable.
- Keystream, mode 0:
  - ks = key_reg[idx*DATA_W +: DATA_W], starting at idx = 0 (least-significant word of the key).
  - On accept, idx advances; it wraps from KEY_W/DATA_W−1 to 0.
- Keystream, mode 1:
  - ks = lfsr[DATA_W-1:0], taken from the state before it advances.
  - On accept, the LFSR takes one Galois step: lfsr <= (lfsr >> 1) ^ (lfsr[0] ? TAPS : 0).
  - A loaded seed of 0 is replaced with 1 to avoid LFSR lock-up.
- key_ld while in RUN:
  - Next state is REKEY; the pending key_in and mode are captured into shadow registers.
  - in_ready = 0 from the next cycle.
- REKEY state:
  - in_ready = 0; keyed = 0.
  - Waits until out_valid = 0, i.e. the last output word has drained.
  - Then applies the shadow key and mode, same as the NOKEY load, and returns to RUN.
  - A further key_ld during REKEY overwrites the shadow registers; the last request wins.
- key_ld on the same cycle as an accept in RUN:
  - The accepted word uses the old key.
  - The new key applies only after the drain.
- keyed = 1 only in RUN.
- in_valid is ignored while in_ready = 0; no word is lost or duplicated.
- Reset asserted mid-stream discards the buffered word immediately (out_valid = 0).

Decomposition:
- Shared package xor_cipher_pkg holds:
  - state enum {NOKEY, RUN, REKEY};
  - default TAPS constant;
  - a function for one Galois LFSR step.
- One natural sub-module: xor_keystream_gen. It owns key_reg, the key index, the LFSR and the mode mux, and exposes ks, an advance strobe and load controls.
- The top level holds the FSM, the output register and word_cnt.

Test Plan:
- Reset, then key_ld with key 0xA55A3CC3, mode 0; stream five words of 0x00 with out_ready = 1:
  - out_data = 0xC3, 0x3C, 0x5A, 0xA5, 0xC3;
  - each word 1 cycle after accept; word_cnt = 5.
- key_ld with key 0x00000001, mode 1; three inputs of 0x00:
  - out_data = 0x01, 0x03, 0x02.
  - Repeat with key 0: outputs are identical (seed forced to 1).
- Backpressure: hold out_ready = 0 for 4 cycles with in_valid = 1:
  - in_ready = 0 after the first accept; out_data stable;
  - no loss or duplication when out_ready returns to 1.
- Rekey mid-stream: key_ld with 0x11111111 while a word is buffered and out_ready = 0:
  - keyed = 0, in_ready = 0 until drain;
  - the next input 0x00 gives 0x11; word_cnt restarts at 1.
- Input before any key: in_valid = 1 in NOKEY gives in_ready = 0 and out_valid = 0.
- Asynchronous reset asserted mid-stream: out_valid, keyed and word_cnt go to 0 without a clock edge. A new key_ld is required before further traffic.

Source files
------------

// File: rtl/xor_cipher_pkg.sv
// rtl/xor_cipher_pkg.sv - shared types, constants and LFSR step for the XOR stream cipher
//
// Contents:
//   cipher_state_e : controller states NOKEY / RUN / REKEY
//   TAPS_DEFAULT   : default Galois feedback mask (32-bit)
//   LFSR_MAX_W     : widest LFSR the step function handles
//   galois_step()  : one right-shifting Galois LFSR step

package xor_cipher_pkg;

  typedef enum logic [1:0] {
    NOKEY = 2'd0,
    RUN   = 2'd1,
    REKEY = 2'd2
  } cipher_state_e;

  localparam logic [31:0] TAPS_DEFAULT = 32'h80200003;

  // The step function works on a fixed wide vector so one definition serves
  // every KEY_W; callers zero-extend into it and truncate the result. The
  // zero-extended upper bits shift in as 0, which is exactly the Galois rule.
  localparam int LFSR_MAX_W = 256;

  function automatic logic [LFSR_MAX_W-1:0] galois_step(
    input logic [LFSR_MAX_W-1:0] state,
    input logic [LFSR_MAX_W-1:0] taps
  );
    return (state >> 1) ^ (state[0] ? taps : '0);
  endfunction

endpackage

// File: rtl/xor_keystream_gen.sv
// rtl/xor_keystream_gen.sv - keystream source: repeating static key or Galois LFSR
//
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   load       : load load_key / load_mode, restart the key index and seed the LFSR
//   load_key   : key (mode 0) or LFSR seed (mode 1)
//   load_mode  : 0 = static repeating key, 1 = LFSR keystream
//   advance    : consume the current keystream word (one per accepted data word)
//   ks         : keystream word for the next accepted data word

module xor_keystream_gen
  import xor_cipher_pkg::*;
#(
  parameter int                 DATA_W = 8,
  parameter int                 KEY_W  = 32,
  parameter logic [KEY_W-1:0]   TAPS   = KEY_W'(TAPS_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [KEY_W-1:0]  load_key,
  input  logic              load_mode,
  input  logic              advance,
  output logic [DATA_W-1:0] ks
);

  localparam int N_WORDS = KEY_W / DATA_W;
  localparam int IDX_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_WORDS - 1);

  if (DATA_W < 1 || KEY_W < DATA_W || (KEY_W % DATA_W) != 0 || KEY_W > LFSR_MAX_W) begin : g_bad_width
    $error("xor_keystream_gen: unsupported DATA_W/KEY_W combination");
  end

  logic [KEY_W-1:0] key_reg;
  logic [KEY_W-1:0] lfsr;
  logic             mode_reg;
  logic [IDX_W-1:0] idx;

  logic [KEY_W-1:0] seed;
  logic [KEY_W-1:0] lfsr_next;

  // An all-zero LFSR never leaves zero, so a zero seed is promoted to 1.
  assign seed      = (load_key == '0) ? KEY_W'(1) : load_key;
  assign lfsr_next = KEY_W'(galois_step(LFSR_MAX_W'(lfsr), LFSR_MAX_W'(TAPS)));

  // Mode 1 uses the low word of the LFSR state before it steps.
  assign ks = mode_reg ? lfsr[DATA_W-1:0] : key_reg[idx*DATA_W +: DATA_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_reg  <= '0;
      lfsr     <= '0;
      mode_reg <= 1'b0;
      idx      <= '0;
    end else if (load) begin
      key_reg  <= load_key;
      mode_reg <= load_mode;
      lfsr     <= seed;
      idx      <= '0;
    end else if (advance) begin
      if (mode_reg) begin
        lfsr <= lfsr_next;
      end else begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/xor_stream_cipher.sv
// rtl/xor_stream_cipher.sv - symmetric XOR stream cipher with valid/ready stream ports
//
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   key_ld, key_in, mode  : key load request (pulse), key/seed, keystream mode
//   in_valid/in_ready/in_data    : input word stream
//   out_valid/out_ready/out_data : output word stream (in_data XOR keystream)
//   keyed                 : high only while in RUN
//   word_cnt              : words accepted since the last key load (wraps)

module xor_stream_cipher
  import xor_cipher_pkg::*;
#(
  parameter int               DATA_W = 8,
  parameter int               KEY_W  = 32,
  parameter logic [KEY_W-1:0] TAPS   = KEY_W'(TAPS_DEFAULT),
  parameter int               CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_ld,
  input  logic [KEY_W-1:0]  key_in,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              keyed,
  output logic [CNT_W-1:0]  word_cnt
);

  cipher_state_e state_q, state_d;

  logic [KEY_W-1:0]  shadow_key;
  logic              shadow_mode;
  logic              cap_shadow;

  logic              ld;
  logic [KEY_W-1:0]  ld_key;
  logic              ld_mode;

  logic              accept;
  logic [DATA_W-1:0] ks;

  // One-stage output register: a new word may enter on the same cycle the
  // buffered one drains.
  assign in_ready = (state_q == RUN) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign keyed    = (state_q == RUN);

  always_comb begin
    state_d    = state_q;
    ld         = 1'b0;
    ld_key     = key_in;
    ld_mode    = mode;
    cap_shadow = 1'b0;
    case (state_q)
      NOKEY: begin
        if (key_ld) begin
          ld      = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        // A word accepted on this cycle still uses the old key; the new key
        // waits in the shadow registers until the output register is empty.
        if (key_ld) begin
          cap_shadow = 1'b1;
          state_d    = REKEY;
        end
      end
      REKEY: begin
        if (key_ld) begin
          cap_shadow = 1'b1;
        end
        if (!out_valid) begin
          ld      = 1'b1;
          state_d = RUN;
          // A request arriving on the apply cycle is the newest; use it directly.
          if (!key_ld) begin
            ld_key  = shadow_key;
            ld_mode = shadow_mode;
          end
        end
      end
      default: begin
        state_d = NOKEY;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= NOKEY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_key  <= '0;
      shadow_mode <= 1'b0;
    end else if (cap_shadow) begin
      shadow_key  <= key_in;
      shadow_mode <= mode;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= in_data ^ ks;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Loads only happen outside RUN, where accept is impossible, so the two
  // branches never compete.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt <= '0;
    end else if (ld) begin
      word_cnt <= '0;
    end else if (accept) begin
      word_cnt <= word_cnt + 1'b1;
    end
  end

  xor_keystream_gen #(
    .DATA_W (DATA_W),
    .KEY_W  (KEY_W),
    .TAPS   (TAPS)
  ) u_ksgen (
    .clk       (clk),
    .rst       (rst),
    .load      (ld),
    .load_key  (ld_key),
    .load_mode (ld_mode),
    .advance   (accept),
    .ks        (ks)
  );

endmodule
